reg_file_sb: RTL and testbench

- Parametrised register file with an integrated per-register scoreboard for the pipelined datapath.
- Provides 2 asynchronous read ports, 1 synchronous write-back port and an issue port.
- The issue port marks destination registers as having outstanding writes. Read ports report busy / stall until the last outstanding write to a source register retires.
- Register 0 is hardwired to zero and is never tracked.

---
 rtl/reg_file_sb.sv | 127 ++++++++++++
 tb/tb_reg_file_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with a per-register outstanding-write scoreboard; register 0 reads as zero and is untracked.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write-back data (and a retiring busy) to the read ports.
module reg_file_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic [ADDR_W-1:0] rd_addr_1,
   input  logic              rd_use_1,
   output logic [DATA_W-1:0] rd_data_1,
   output logic              busy_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   input  logic              rd_use_2,
   output logic [DATA_W-1:0] rd_data_2,
   output logic              busy_2,
   output logic              stall,
   output logic              issue_err,
   output logic              wb_err
);

   localparam int               DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Entry 0 of both arrays is cleared by reset and never written, so it stays zero.
   logic [DATA_W-1:0] regs    [DEPTH];
   logic [CNT_W-1:0]  cnt     [DEPTH];
   logic [CNT_W-1:0]  cnt_nxt [DEPTH];
   logic [CNT_W+1:0]  step;
   logic              issue_err_nxt;
   logic              wb_err_nxt;

   // Saturating counter step; returns {issue_err, wb_err, next_count}.
   function automatic logic [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
      logic [CNT_W-1:0] n;
      logic             ie;
      logic             we;
      n  = c;
      ie = 1'b0;
      we = 1'b0;
      if (inc && !dec) begin
         if (c == CNT_MAX) ie = 1'b1;
         else              n  = c + CNT_ONE;
      end else if (dec && !inc) begin
         if (c == '0) we = 1'b1;
         else         n  = c - CNT_ONE;
      end
      return {ie, we, n};
   endfunction

`ifdef REG_FILE_SB_BYPASS_EN
   // Write-through: a matching write-back this cycle supplies the data, and
   // retires the last outstanding write unless a new issue re-arms it.
   function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] stored,
                                                 input logic [CNT_W-1:0]  c);
      logic [DATA_W-1:0] d;
      logic              b;
      logic              hit;
      hit = wr_en && (wr_addr == a) && (a != '0);
      d   = (a == '0) ? '0 : stored;
      b   = (a != '0) && (c != '0);
      if (hit) begin
         d = wr_data;
         if ((c == CNT_ONE) && !(issue_en && (issue_dest == a))) b = 1'b0;
      end
      return {b, d};
   endfunction
`else
   function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] stored,
                                                 input logic [CNT_W-1:0]  c);
      logic [DATA_W-1:0] d;
      logic              b;
      d = (a == '0) ? '0 : stored;
      b = (a != '0) && (c != '0);
      return {b, d};
   endfunction
`endif

   always_comb begin
      issue_err_nxt = 1'b0;
      wb_err_nxt    = 1'b0;
      step          = '0;
      cnt_nxt[0]    = '0;
      for (int r = 1; r < DEPTH; r++) begin
         step = cnt_step(cnt[r],
                         issue_en && (issue_dest == ADDR_W'(r)),
                         wr_en && (wr_addr == ADDR_W'(r)));
         cnt_nxt[r]    = step[CNT_W-1:0];
         issue_err_nxt = issue_err_nxt | step[CNT_W+1];
         wb_err_nxt    = wb_err_nxt | step[CNT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         issue_err <= 1'b0;
         wb_err    <= 1'b0;
      end else begin
         for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
         if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
         issue_err <= issue_err_nxt;
         wb_err    <= wb_err_nxt;
      end
   end

   always_comb begin
      {busy_1, rd_data_1} = read_port(rd_addr_1, regs[rd_addr_1], cnt[rd_addr_1]);
      {busy_2, rd_data_2} = read_port(rd_addr_2, regs[rd_addr_2], cnt[rd_addr_2]);
      stall               = (busy_1 & rd_use_1) | (busy_2 & rd_use_2);
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb; each row is driven before an edge and the outputs checked before that edge.
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        issue_en = 1'b0;
   logic [2:0]  issue_dest = '0;
   logic [2:0]  rd_addr_1 = '0;
   logic        rd_use_1 = 1'b0;
   logic [15:0] rd_data_1;
   logic        busy_1;
   logic [2:0]  rd_addr_2 = '0;
   logic        rd_use_2 = 1'b0;
   logic [15:0] rd_data_2;
   logic        busy_2;
   logic        stall;
   logic        issue_err;
   logic        wb_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_dest(issue_dest),
      .rd_addr_1(rd_addr_1), .rd_use_1(rd_use_1), .rd_data_1(rd_data_1), .busy_1(busy_1),
      .rd_addr_2(rd_addr_2), .rd_use_2(rd_use_2), .rd_data_2(rd_data_2), .busy_2(busy_2),
      .stall(stall), .issue_err(issue_err), .wb_err(wb_err)
   );

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        ie;
      logic [2:0]  id;
      logic [2:0]  ra1;
      logic        u1;
      logic [2:0]  ra2;
      logic        u2;
      logic [15:0] d1;
      logic        b1;
      logic [15:0] d2;
      logic        b2;
      logic        st;
      logic        ierr;
      logic        werr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic ie, input logic [2:0] id,
                               input logic [2:0] ra1, input logic u1, input logic [2:0] ra2, input logic u2,
                               input logic [15:0] d1, input logic b1, input logic [15:0] d2, input logic b2,
                               input logic st, input logic ierr, input logic werr);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.id = id;
      v.ra1 = ra1; v.u1 = u1; v.ra2 = ra2; v.u2 = u2;
      v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2;
      v.st = st; v.ierr = ierr; v.werr = werr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_row(input vec_t v, input int idx);
      @(negedge clk);
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      issue_en = v.ie; issue_dest = v.id;
      rd_addr_1 = v.ra1; rd_use_1 = v.u1; rd_addr_2 = v.ra2; rd_use_2 = v.u2;
      #1;
      chk($sformatf("row%0d rd_data_1", idx), 32'(rd_data_1), 32'(v.d1));
      chk($sformatf("row%0d busy_1", idx), 32'(busy_1), 32'(v.b1));
      chk($sformatf("row%0d rd_data_2", idx), 32'(rd_data_2), 32'(v.d2));
      chk($sformatf("row%0d busy_2", idx), 32'(busy_2), 32'(v.b2));
      chk($sformatf("row%0d stall", idx), 32'(stall), 32'(v.st));
      chk($sformatf("row%0d issue_err", idx), 32'(issue_err), 32'(v.ierr));
      chk($sformatf("row%0d wb_err", idx), 32'(wb_err), 32'(v.werr));
   endtask

   initial begin
      // reads of every address after reset
      for (int i = 0; i < 8; i++) vecs.push_back(mk(0,0,0, 0,0, 3'(i),1, 3'(7-i),1, 0,0,0,0, 0,0,0));
      // writes to register 0 are dropped and do not flag wb_err
      vecs.push_back(mk(1,0,16'hBEEF, 0,0, 0,1,0,1, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,1,0,1, 0,0,0,0, 0,0,0));
      // single issue / write-back on register 3
      vecs.push_back(mk(0,0,0,        1,3, 3,1,0,0, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 3,1,0,0, 0,1,0,0, 1,0,0));
      vecs.push_back(mk(1,3,16'h1234, 0,0, 0,0,2,0, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 3,1,0,0, 16'h1234,0,0,0, 0,0,0));
      // saturate register 5, then overflow once
      vecs.push_back(mk(0,0,0,        1,5, 0,0,5,1, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        1,5, 0,0,5,1, 0,0,0,1, 1,0,0));
      vecs.push_back(mk(0,0,0,        1,5, 0,0,5,1, 0,0,0,1, 1,0,0));
      vecs.push_back(mk(0,0,0,        1,5, 0,0,5,1, 0,0,0,1, 1,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,0,5,1, 0,0,0,1, 1,1,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,0,5,1, 0,0,0,1, 1,0,0));
      // three write-backs to register 5; busy clears only after the last
      vecs.push_back(mk(1,5,16'h0505, 0,0, 3,1,0,0, 16'h1234,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,0,5,1, 0,0,16'h0505,1, 1,0,0));
      vecs.push_back(mk(1,5,16'h0506, 0,0, 3,1,0,0, 16'h1234,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,0,5,1, 0,0,16'h0506,1, 1,0,0));
      vecs.push_back(mk(1,5,16'h0507, 0,0, 3,1,0,0, 16'h1234,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,0,5,1, 0,0,16'h0507,0, 0,0,0));
      // simultaneous issue and write-back on register 2 with count 1
      vecs.push_back(mk(0,0,0,        1,2, 2,1,0,0, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,2,16'h2222, 1,2, 5,1,3,1, 16'h0507,0,16'h1234,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 2,1,0,0, 16'h2222,1,0,0, 1,0,0));
      // write-back underflow on register 6; busy without use does not stall
      vecs.push_back(mk(1,6,16'h6666, 0,0, 2,0,0,0, 16'h2222,1,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        1,4, 6,1,4,0, 16'h6666,0,0,0, 0,0,1));
      vecs.push_back(mk(0,0,0,        1,0, 2,0,4,0, 16'h2222,1,0,1, 0,0,0));
      vecs.push_back(mk(0,0,0,        0,0, 0,1,4,1, 0,0,0,1, 1,0,0));
      // register 7 loaded with 1 and one outstanding write, then same-cycle write-back
      vecs.push_back(mk(1,7,16'h0001, 0,0, 0,0,0,0, 0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,        1,7, 7,1,0,0, 16'h0001,0,0,0, 0,0,1));
      vecs.push_back(mk(1,7,16'hA5A5, 0,0, 7,1,7,0,
                        BYP ? 16'hA5A5 : 16'h0001, !BYP, BYP ? 16'hA5A5 : 16'h0001, !BYP, !BYP, 0,0));
      vecs.push_back(mk(0,0,0,        0,0, 7,1,0,0, 16'hA5A5,0,0,0, 0,0,0));

      // reset state
      rst = 1'b1;
      rd_addr_1 = 3; rd_use_1 = 1; rd_addr_2 = 5; rd_use_2 = 1;
      #3;
      chk("reset rd_data_1", 32'(rd_data_1), 32'h0);
      chk("reset busy_1", 32'(busy_1), 32'h0);
      chk("reset rd_data_2", 32'(rd_data_2), 32'h0);
      chk("reset busy_2", 32'(busy_2), 32'h0);
      chk("reset stall", 32'(stall), 32'h0);
      chk("reset issue_err", 32'(issue_err), 32'h0);
      chk("reset wb_err", 32'(wb_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

      // asynchronous reset mid-operation: registers 2 and 4 each have one outstanding write
      @(negedge clk);
      wr_en = 0; issue_en = 0;
      rd_addr_1 = 2; rd_use_1 = 1; rd_addr_2 = 4; rd_use_2 = 1;
      #1;
      chk("pre-reset busy_1", 32'(busy_1), 32'h1);
      chk("pre-reset rd_data_1", 32'(rd_data_1), 32'h2222);
      #2 rst = 1'b1;
      #1;
      chk("mid-reset rd_data_1", 32'(rd_data_1), 32'h0);
      chk("mid-reset busy_1", 32'(busy_1), 32'h0);
      chk("mid-reset busy_2", 32'(busy_2), 32'h0);
      chk("mid-reset stall", 32'(stall), 32'h0);
      issue_en = 1; issue_dest = 2;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post-reset issue busy_1", 32'(busy_1), 32'h1);
      chk("post-reset issue stall", 32'(stall), 32'h1);
      chk("post-reset rd_data_1", 32'(rd_data_1), 32'h0);
      issue_en = 0; wr_en = 1; wr_addr = 2; wr_data = 16'h0F0F; rd_addr_1 = 3;
      @(posedge clk);
      #1;
      wr_en = 0; rd_addr_1 = 2;
      #1;
      chk("post-reset wb busy_1", 32'(busy_1), 32'h0);
      chk("post-reset wb rd_data_1", 32'(rd_data_1), 32'h0F0F);
      chk("post-reset wb_err", 32'(wb_err), 32'h0);
      chk("post-reset issue_err", 32'(issue_err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
